// File: rtl/cam_byte_packer.sv
// OV5640 byte packer: registers the camera bus, pairs bytes into RGB565 words tagged {sof, eol},
// and drops whole lines at prog_full. `define CAM_TEST_PATTERN_EN replaces pixel data with x index.
module cam_byte_packer #(
    parameter int PIX_W     = 16,
    parameter int VSYNC_POL = 1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cam_vsync,
    input  logic               cam_href,
    input  logic [7:0]         cam_data,
    output logic [PIX_W+1:0]   fifo_din,
    output logic               fifo_wr_en,
    input  logic               fifo_full,
    input  logic               fifo_prog_full,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic [CNT_W-1:0]   line_drop_cnt,
    output logic               pix_ovf,
    output logic               odd_err
);
    typedef enum logic [2:0] {IDLE, WAIT_LINE, BYTE_HI, BYTE_LO, DROP} state_t;

    // Input stage: every decision below uses these sampled copies
    logic             cam_vsync_q, cam_href_q;
    logic [7:0]       cam_data_q;
    logic             vs_act_prev_q, href_prev_q;
    state_t           state_q, state_d;
    logic [7:0]       hi_q, hi_d;
    logic [PIX_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             sof_pend_q, sof_pend_d;
    logic             wr_en_q, wr_en_d;
    logic [PIX_W+1:0] din_q, din_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             pix_ovf_q, pix_ovf_d;
    logic             odd_err_q, odd_err_d;

    logic             vs_act, frame_start, href_rise;
    logic [PIX_W-1:0] pixel_new;

    assign vs_act      = (VSYNC_POL != 0) ? cam_vsync_q : ~cam_vsync_q;
    assign frame_start = vs_act & ~vs_act_prev_q;
    assign href_rise   = cam_href_q & ~href_prev_q;

`ifdef CAM_TEST_PATTERN_EN
    logic [PIX_W-1:0] x_q, x_d;

    always_comb begin
        x_d = x_q;
        if (!frame_start) begin
            if (state_q == WAIT_LINE && href_rise)
                x_d = '0;
            else if (state_q == BYTE_LO && cam_href_q)
                x_d = x_q + PIX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) x_q <= '0;
        else        x_q <= x_d;
    end

    assign pixel_new = x_q;
`else
    assign pixel_new = {hi_q, cam_data_q};
`endif

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        sof_pend_d  = sof_pend_q;
        wr_en_d     = 1'b0;
        din_d       = din_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        pix_ovf_d   = pix_ovf_q;
        odd_err_d   = odd_err_q;

        if (frame_start) begin
            // Any partial line is abandoned without a write and counted as dropped
            if (state_q == BYTE_HI || state_q == BYTE_LO) begin
                if (~&drop_cnt_q) drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            sof_pend_d  = 1'b1;
            pix_ovf_d   = 1'b0;
            odd_err_d   = 1'b0;
            pend_v_d    = 1'b0;
            state_d     = WAIT_LINE;
        end else begin
            if (wr_en_q && fifo_full) pix_ovf_d = 1'b1;
            case (state_q)
                WAIT_LINE: if (href_rise) begin
                    if (fifo_prog_full) begin
                        if (~&drop_cnt_q) drop_cnt_d = drop_cnt_q + CNT_W'(1);
                        state_d = DROP;
                    end else begin
                        hi_d    = cam_data_q;
                        state_d = BYTE_LO;
                    end
                end
                BYTE_LO: begin
                    if (cam_href_q) begin
                        if (pend_v_q) begin
                            wr_en_d = 1'b1;
                            din_d   = {sof_pend_q, 1'b0, pend_q};
                        end
                        pend_d   = pixel_new;
                        pend_v_d = 1'b1;
                        state_d  = BYTE_HI;
                    end else begin
                        odd_err_d = 1'b1;
                        if (pend_v_q) begin
                            wr_en_d = 1'b1;
                            din_d   = {sof_pend_q, 1'b1, pend_q};
                        end
                        pend_v_d = 1'b0;
                        state_d  = WAIT_LINE;
                    end
                end
                BYTE_HI: begin
                    if (cam_href_q) begin
                        hi_d    = cam_data_q;
                        state_d = BYTE_LO;
                    end else begin
                        if (pend_v_q) begin
                            wr_en_d = 1'b1;
                            din_d   = {sof_pend_q, 1'b1, pend_q};
                        end
                        pend_v_d = 1'b0;
                        state_d  = WAIT_LINE;
                    end
                end
                DROP: if (!cam_href_q) state_d = WAIT_LINE;
                default: ;
            endcase
            if (wr_en_d) sof_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_vsync_q   <= 1'b0;
            cam_href_q    <= 1'b0;
            cam_data_q    <= '0;
            vs_act_prev_q <= 1'b0;
            href_prev_q   <= 1'b0;
            state_q       <= IDLE;
            hi_q          <= '0;
            pend_q        <= '0;
            pend_v_q      <= 1'b0;
            sof_pend_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            din_q         <= '0;
            frame_cnt_q   <= '0;
            drop_cnt_q    <= '0;
            pix_ovf_q     <= 1'b0;
            odd_err_q     <= 1'b0;
        end else begin
            cam_vsync_q   <= cam_vsync;
            cam_href_q    <= cam_href;
            cam_data_q    <= cam_data;
            vs_act_prev_q <= vs_act;
            href_prev_q   <= cam_href_q;
            state_q       <= state_d;
            hi_q          <= hi_d;
            pend_q        <= pend_d;
            pend_v_q      <= pend_v_d;
            sof_pend_q    <= sof_pend_d;
            wr_en_q       <= wr_en_d;
            din_q         <= din_d;
            frame_cnt_q   <= frame_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            pix_ovf_q     <= pix_ovf_d;
            odd_err_q     <= odd_err_d;
        end
    end

    assign fifo_din      = din_q;
    assign fifo_wr_en    = wr_en_q;
    assign frame_cnt     = frame_cnt_q;
    assign line_drop_cnt = drop_cnt_q;
    assign pix_ovf       = pix_ovf_q;
    assign odd_err       = odd_err_q;
endmodule

// File: tb/tb_cam_byte_packer.sv
// Scoreboard bench for cam_byte_packer: expected FIFO words are queued as lines are driven
// and compared in order against every fifo_wr_en strobe.
module tb_cam_byte_packer;
    localparam int PIX_W = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cam_vsync = 1'b0, cam_href = 1'b0;
    logic [7:0]       cam_data = '0;
    logic [PIX_W+1:0] fifo_din;
    logic             fifo_wr_en;
    logic             fifo_full = 1'b0, fifo_prog_full = 1'b0;
    logic [CNT_W-1:0] frame_cnt, line_drop_cnt;
    logic             pix_ovf, odd_err;

    cam_byte_packer #(.PIX_W(PIX_W), .VSYNC_POL(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full), .fifo_prog_full(fifo_prog_full), .frame_cnt(frame_cnt),
        .line_drop_cnt(line_drop_cnt), .pix_ovf(pix_ovf), .odd_err(odd_err));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    logic [PIX_W+1:0] exp_q[$];
    int               wr_cyc_q[$];
    logic [7:0]       line_buf[0:1023];
    bit               sof_exp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && fifo_wr_en) begin
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) chk("unexpected_write", 64'(fifo_din), 64'h0);
            else                   chk("fifo_word", 64'(fifo_din), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        cam_vsync = 1'b1;
        tick(1);
        cam_vsync = 1'b0;
        tick(3);
        sof_exp = 1'b1;
    endtask

    // Pushes expected words for line_buf[0..n-1] then drives it; drop suppresses expectations
    task automatic send_line(input int n, input bit drop);
        int npix;
        logic [PIX_W-1:0] pix;
        npix = n / 2;
        if (!drop) begin
            for (int p = 0; p < npix; p++) begin
`ifdef CAM_TEST_PATTERN_EN
                pix = PIX_W'(p);
`else
                pix = {line_buf[2*p], line_buf[2*p+1]};
`endif
                exp_q.push_back({sof_exp && (p == 0), p == npix - 1, pix});
            end
            if (npix > 0) sof_exp = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            cam_href = 1'b1;
            cam_data = line_buf[i];
            tick(1);
        end
        cam_href = 1'b0;
        cam_data = '0;
        tick(6);
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) line_buf[i] = base + 8'(i);
    endtask

    initial begin
        int k;
        tick(3);
        chk("rst_wr_en", 64'(fifo_wr_en), 64'h0);
        chk("rst_din", 64'(fifo_din), 64'h0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'h0);
        chk("rst_drop_cnt", 64'(line_drop_cnt), 64'h0);
        chk("rst_flags", 64'({pix_ovf, odd_err}), 64'h0);
        rst_n = 1'b1;
        tick(2);

        // href before any frame start is ignored
        fill(4, 8'hA0);
        send_line(4, 1'b1);

        // First line: exact latency and content
        frame_start();
        chk("frame_cnt_1", 64'(frame_cnt), 64'd1);
        line_buf[0] = 8'h12; line_buf[1] = 8'h34; line_buf[2] = 8'h56; line_buf[3] = 8'h78;
        wr_cyc_q.delete();
        k = cyc;
        send_line(4, 1'b0);
        chk("lat_nwr", 64'(wr_cyc_q.size()), 64'd2);
        if (wr_cyc_q.size() == 2) begin
            chk("lat_w0", 64'(wr_cyc_q[0]), 64'(k + 5));
            chk("lat_w1", 64'(wr_cyc_q[1]), 64'(k + 6));
        end

        // Two long lines in one frame
        frame_start();
        fill(640, 8'h00);
        wr_cyc_q.delete();
        send_line(640, 1'b0);
        fill(640, 8'h37);
        send_line(640, 1'b0);
        chk("long_nwr", 64'(wr_cyc_q.size()), 64'd640);
        chk("frame_cnt_2", 64'(frame_cnt), 64'd2);

        // Line 2 of 3 dropped by prog_full
        frame_start();
        fill(8, 8'h10); send_line(8, 1'b0);
        fifo_prog_full = 1'b1;
        fill(8, 8'h20); send_line(8, 1'b1);
        fifo_prog_full = 1'b0;
        fill(8, 8'h30); send_line(8, 1'b0);
        chk("drop_cnt_1", 64'(line_drop_cnt), 64'd1);

        // Odd-length line
        frame_start();
        fill(5, 8'h01); send_line(5, 1'b0);
        chk("odd_err_set", 64'(odd_err), 64'd1);
        frame_start();
        chk("odd_err_clr", 64'(odd_err), 64'd0);

        // Overflow flag while the FIFO reports full
        fifo_full = 1'b1;
        fill(6, 8'h40); send_line(6, 1'b0);
        fifo_full = 1'b0;
        chk("pix_ovf_set", 64'(pix_ovf), 64'd1);
        fill(4, 8'h50); send_line(4, 1'b0);
        chk("pix_ovf_hold", 64'(pix_ovf), 64'd1);

        // vsync mid-line: pending pixel discarded, line counted as dropped
        fill(4, 8'h60);
        for (int i = 0; i < 4; i++) begin
            cam_href = 1'b1;
            cam_data = line_buf[i];
            cam_vsync = (i == 3);
            tick(1);
        end
        cam_href = 1'b0; cam_vsync = 1'b0; cam_data = '0;
        sof_exp = 1'b1;
        tick(6);
        chk("drop_cnt_2", 64'(line_drop_cnt), 64'd2);
        chk("pix_ovf_clr", 64'(pix_ovf), 64'd0);
        chk("frame_cnt_6", 64'(frame_cnt), 64'd6);
        fill(4, 8'h70); send_line(4, 1'b0);

        // 8-byte line: x-index pattern when enabled, camera bytes otherwise
        frame_start();
        fill(8, 8'hC0); send_line(8, 1'b0);

        tick(4);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
